inst_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder in the CPU pipeline. It owns the fetch PC (word-indexed, incremented by 1 per instruction), reads a synchronous 1-cycle-latency instruction ROM, and buffers returned words in a 2-entry FIFO. It presents instruction plus PC to the decoder over a valid/ready handshake. Taken jumps and branches from the execute stage redirect it, flushing all in-flight and buffered instructions.

---
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: word PC, 1-cycle ROM, 2-entry FIFO to decoder.
// Ports: CLK/RST, IMEM_* ROM port, REDIRECT_* flush, OUT_* handshake, FETCH_DONE.
module inst_fetch #(
  parameter int ADDR_W   = 8,
  parameter int LAST_PC  = 18,
  parameter int RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_EN,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [31:0]       IMEM_DATA,
  input  logic              REDIRECT_VALID,
  input  logic [31:0]       REDIRECT_PC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [31:0]       OUT_INST,
  output logic [31:0]       OUT_PC,
  output logic              FETCH_DONE
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  localparam logic [31:0] LAST = 32'(LAST_PC);
  localparam logic [31:0] RPC  = 32'(RESET_PC);

  logic [31:0] fpc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic [1:0]  occ;
  entry_t      q0;
  entry_t      q1;
  entry_t      nxt;

  logic        pop;
  logic        push;
  logic        in_range;
  logic        redir_ok;
  logic        credit;
  logic        empty;
  logic        full;
  logic [2:0]  level;

  always_comb begin
    in_range  = fpc <= LAST;
    redir_ok  = REDIRECT_PC <= LAST;
    empty     = occ == 2'd0;
    full      = occ == 2'd2;
    OUT_VALID = !RST & !REDIRECT_VALID & !empty;
    pop       = OUT_VALID & OUT_READY;
    push      = resp_valid & !REDIRECT_VALID;
    // Occupancy after this cycle counting the word still in flight;
    // issuing only below 2 means a push never meets a full FIFO.
    level     = {1'b0, occ} + {2'b0, resp_valid} - {2'b0, pop};
    credit    = level < 3'd2;
    IMEM_EN   = !RST &
                (REDIRECT_VALID ? redir_ok : (in_range & credit));
    IMEM_ADDR = REDIRECT_VALID ? REDIRECT_PC[ADDR_W-1:0]
                               : fpc[ADDR_W-1:0];
    OUT_INST  = empty ? 32'd0 : q0.inst;
    OUT_PC    = empty ? 32'd0 : q0.pc;
    FETCH_DONE = !in_range & empty & !resp_valid;
    nxt.inst  = IMEM_DATA;
    nxt.pc    = resp_pc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc        <= RPC;
      occ        <= 2'd0;
      resp_valid <= 1'b0;
      resp_pc    <= 32'd0;
      q0         <= '0;
      q1         <= '0;
    end else begin
      resp_valid <= IMEM_EN;
      resp_pc    <= REDIRECT_VALID ? REDIRECT_PC : fpc;
      if (REDIRECT_VALID) begin
        occ <= 2'd0;
        fpc <= redir_ok ? REDIRECT_PC + 32'd1 : REDIRECT_PC;
      end else begin
        if (IMEM_EN)
          fpc <= fpc + 32'd1;
        occ <= level[1:0];
        // q0 is always the head; entries shift down on pop.
        unique case (1'b1)
          push & pop & full: begin
            q0 <= q1;
            q1 <= nxt;
          end
          push & pop & !full: q0 <= nxt;
          pop & !push:        q0 <= q1;
          push & !pop & empty:  q0 <= nxt;
          push & !pop & !empty: q1 <= nxt;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a bench-side 1-cycle ROM model.
// Tasks cover reset, streaming, stall, redirects and mid-run reset.
module tb_inst_fetch;

  logic        CLK;
  logic        RST;
  logic        IMEM_EN;
  logic [7:0]  IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INST;
  logic [31:0] OUT_PC;
  logic        FETCH_DONE;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_W(8), .LAST_PC(18), .RESET_PC(0)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_EN(IMEM_EN), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_INST(OUT_INST), .OUT_PC(OUT_PC), .FETCH_DONE(FETCH_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1357_0000 + a * 32'd3 + 32'd1;
  endfunction

  always @(posedge CLK)
    if (IMEM_EN) IMEM_DATA <= rom_word({24'd0, IMEM_ADDR});

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench just after the edge that opens cycle 0.
  task automatic start(input logic rdy);
    RST = 1'b1;
    REDIRECT_VALID = 1'b0;
    OUT_READY = rdy;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    checks++; if (IMEM_EN !== 1'b0) begin errors++; $display("FAIL rst_en got %0b exp 0", IMEM_EN); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", OUT_VALID); end
    checks++; if (OUT_INST !== 32'd0) begin errors++; $display("FAIL rst_inst got %0h exp 0", OUT_INST); end
    checks++; if (OUT_PC !== 32'd0) begin errors++; $display("FAIL rst_pc got %0d exp 0", OUT_PC); end
    checks++; if (FETCH_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", FETCH_DONE); end
  endtask

  task automatic test_stream();
    logic ev;
    start(1'b1);
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      ev = (c >= 2) && (c <= 20);
      checks++; if (OUT_VALID !== ev) begin errors++; $display("FAIL stream_valid c=%0d got %0b exp %0b", c, OUT_VALID, ev); end
      if (ev) begin
        checks++; if (OUT_PC !== 32'(c - 2)) begin errors++; $display("FAIL stream_pc c=%0d got %0d exp %0d", c, OUT_PC, c - 2); end
        checks++; if (OUT_INST !== rom_word(32'(c - 2))) begin errors++; $display("FAIL stream_inst c=%0d got %0h exp %0h", c, OUT_INST, rom_word(32'(c - 2))); end
      end
      if (c == 0) begin
        checks++; if (IMEM_EN !== 1'b1) begin errors++; $display("FAIL c0_en got %0b exp 1", IMEM_EN); end
        checks++; if (IMEM_ADDR !== 8'd0) begin errors++; $display("FAIL c0_addr got %0d exp 0", IMEM_ADDR); end
      end
      if (c <= 19 || c >= 21) begin
        checks++; if (FETCH_DONE !== (c >= 21)) begin errors++; $display("FAIL stream_done c=%0d got %0b exp %0b", c, FETCH_DONE, c >= 21); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int exp_pc;
    exp_pc = 0;
    start(1'b1);
    for (int c = 0; c < 27; c++) begin
      OUT_READY = !((c >= 5) && (c <= 8));
      @(negedge CLK);
      if (c >= 5 && c <= 8) begin
        checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd3) begin errors++; $display("FAIL stall_hold c=%0d got v=%0b pc=%0d exp v=1 pc=3", c, OUT_VALID, OUT_PC); end
      end
      if (c >= 6 && c <= 8) begin
        checks++; if (IMEM_EN !== 1'b0) begin errors++; $display("FAIL stall_en c=%0d got %0b exp 0", c, IMEM_EN); end
      end
      if (OUT_VALID && OUT_READY) begin
        checks++; if (OUT_PC !== 32'(exp_pc)) begin errors++; $display("FAIL stall_seq c=%0d got %0d exp %0d", c, OUT_PC, exp_pc); end
        checks++; if (OUT_INST !== rom_word(32'(exp_pc))) begin errors++; $display("FAIL stall_inst c=%0d got %0h exp %0h", c, OUT_INST, rom_word(32'(exp_pc))); end
        exp_pc++;
      end
      tick();
    end
    checks++; if (exp_pc != 19) begin errors++; $display("FAIL stall_count got %0d exp 19", exp_pc); end
  endtask

  task automatic test_redirect();
    start(1'b0);
    tick();
    tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'd5;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL redir_n_valid got %0b exp 0", OUT_VALID); end
    checks++; if (IMEM_EN !== 1'b1 || IMEM_ADDR !== 8'd5) begin errors++; $display("FAIL redir_n_req got en=%0b a=%0d exp en=1 a=5", IMEM_EN, IMEM_ADDR); end
    tick();
    REDIRECT_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got %0b exp 0", OUT_VALID); end
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'(5 + k)) begin errors++; $display("FAIL redir_seq k=%0d got v=%0b pc=%0d exp v=1 pc=%0d", k, OUT_VALID, OUT_PC, 5 + k); end
      checks++; if (OUT_INST !== rom_word(32'(5 + k))) begin errors++; $display("FAIL redir_inst k=%0d got %0h exp %0h", k, OUT_INST, rom_word(32'(5 + k))); end
    end
    tick();
    OUT_READY = 1'b0;
    tick();
    tick();
    tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'd12;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0 || IMEM_ADDR !== 8'd12) begin errors++; $display("FAIL full_redir got v=%0b a=%0d exp v=0 a=12", OUT_VALID, IMEM_ADDR); end
    tick();
    REDIRECT_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL full_n1 got %0b exp 0", OUT_VALID); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd12) begin errors++; $display("FAIL full_n2 got v=%0b pc=%0d exp v=1 pc=12", OUT_VALID, OUT_PC); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd13) begin errors++; $display("FAIL full_n3 got v=%0b pc=%0d exp v=1 pc=13", OUT_VALID, OUT_PC); end
  endtask

  task automatic test_redirect_oob();
    start(1'b1);
    for (int i = 0; i < 6; i++) tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'd25;
    @(negedge CLK);
    checks++; if (IMEM_EN !== 1'b0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL oob_n got en=%0b v=%0b exp 0 0", IMEM_EN, OUT_VALID); end
    tick();
    REDIRECT_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0 || IMEM_EN !== 1'b0) begin errors++; $display("FAIL oob_idle k=%0d got v=%0b en=%0b exp 0 0", k, OUT_VALID, IMEM_EN); end
      checks++; if (FETCH_DONE !== 1'b1) begin errors++; $display("FAIL oob_done k=%0d got %0b exp 1", k, FETCH_DONE); end
      tick();
    end
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'd2;
    @(negedge CLK);
    checks++; if (IMEM_EN !== 1'b1 || IMEM_ADDR !== 8'd2) begin errors++; $display("FAIL back_req got en=%0b a=%0d exp 1 2", IMEM_EN, IMEM_ADDR); end
    checks++; if (FETCH_DONE !== 1'b1) begin errors++; $display("FAIL back_done_n got %0b exp 1", FETCH_DONE); end
    tick();
    REDIRECT_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (FETCH_DONE !== 1'b0 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL back_n1 got done=%0b v=%0b exp 0 0", FETCH_DONE, OUT_VALID); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd2) begin errors++; $display("FAIL back_n2 got v=%0b pc=%0d exp v=1 pc=2", OUT_VALID, OUT_PC); end
  endtask

  task automatic test_redirect_vs_ready();
    start(1'b1);
    for (int i = 0; i < 5; i++) tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd3) begin errors++; $display("FAIL race_pre got v=%0b pc=%0d exp v=1 pc=3", OUT_VALID, OUT_PC); end
    tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'd10;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL race_n got %0b exp 0", OUT_VALID); end
    tick();
    REDIRECT_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL race_n1 got %0b exp 0", OUT_VALID); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd10) begin errors++; $display("FAIL race_n2 got v=%0b pc=%0d exp v=1 pc=10", OUT_VALID, OUT_PC); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_PC !== 32'd11) begin errors++; $display("FAIL race_n3 got %0d exp 11", OUT_PC); end
  endtask

  task automatic test_mid_reset();
    start(1'b0);
    for (int i = 0; i < 4; i++) tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd0 || IMEM_EN !== 1'b0) begin errors++; $display("FAIL mrst_full got v=%0b pc=%0d en=%0b exp 1 0 0", OUT_VALID, OUT_PC, IMEM_EN); end
    tick();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0 || IMEM_EN !== 1'b0) begin errors++; $display("FAIL mrst_during got v=%0b en=%0b exp 0 0", OUT_VALID, IMEM_EN); end
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0 || OUT_PC !== 32'd0) begin errors++; $display("FAIL mrst_c0 got v=%0b pc=%0d exp 0 0", OUT_VALID, OUT_PC); end
    checks++; if (IMEM_EN !== 1'b1 || IMEM_ADDR !== 8'd0) begin errors++; $display("FAIL mrst_req got en=%0b a=%0d exp 1 0", IMEM_EN, IMEM_ADDR); end
    tick();
    OUT_READY = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mrst_c1 got %0b exp 0", OUT_VALID); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd0 || OUT_INST !== rom_word(32'd0)) begin errors++; $display("FAIL mrst_c2 got v=%0b pc=%0d i=%0h exp 1 0 %0h", OUT_VALID, OUT_PC, OUT_INST, rom_word(32'd0)); end
    tick();
    @(negedge CLK);
    checks++; if (OUT_PC !== 32'd1) begin errors++; $display("FAIL mrst_c3 got %0d exp 1", OUT_PC); end
  endtask

  initial begin
    RST = 1'b1;
    OUT_READY = 1'b0;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_oob();
    test_redirect_vs_ready();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
